fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single 8-bit write port of the team's FIFO between NUM_REQ producers.
- Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to BURST_LEN words.
- The arbiter drives the FIFO's data-in and write-enable, and honours the FIFO's full flag.
- It sits between the producer blocks and the FIFO instance; the FIFO read side is untouched.

---
 rtl/fifo_wr_arbiter_pkg.sv | 38 +++
 rtl/fifo_wr_arbiter_pick.sv | 23 ++
 rtl/fifo_wr_arbiter.sv | 110 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// rr_pick is the reusable round-robin search used by rr_pick_comb.
package fifo_wr_arbiter_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned PTR_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } pick_t;

    // First set bit of valid scanning last_ptr+1, last_ptr+2, ... modulo num_req.
    function automatic pick_t rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [PTR_W-1:0]   last_ptr,
        input int unsigned        num_req
    );
        pick_t       pick;
        int unsigned cand;
        pick = '0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            cand = (32'(last_ptr) + k) % num_req;
            if ((k <= num_req) && !pick.found && valid[cand[PTR_W-1:0]]) begin
                pick.found = 1'b1;
                pick.idx   = cand[PTR_W-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_pick.sv
// Combinational round-robin selector: valid vector + last owner -> next owner.
module rr_pick_comb
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   last_ptr,
    output logic [IDX_W-1:0]   sel,
    output logic               found
);

    pick_t pick;

    always_comb begin
        pick = rr_pick(MAX_REQ'(valid), PTR_W'(last_ptr), NUM_REQ);
    end

    assign sel   = IDX_W'(pick.idx);
    assign found = pick.found;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NUM_REQ producers,
// granting one producer at a time for bursts of up to BURST_LEN words.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        REQ_VALID,
    input  logic [DATA_W*NUM_REQ-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]        REQ_READY,
    input  logic                      FIFO_FULL,
    output logic [DATA_W-1:0]         FIFO_DIN,
    output logic                      FIFO_WR_EN,
    output logic [NUM_REQ-1:0]        GRANT,
    output logic                      BUSY,
    output logic [CNT_W-1:0]          STALL_CNT
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    state_t              state, state_n;
    logic [IDX_W-1:0]    last_ptr, last_ptr_n;
    logic [BEAT_W-1:0]   beat_cnt, beat_n;
    logic [NUM_REQ-1:0]  grant_n;
    logic [CNT_W-1:0]    stall_n;
    logic [IDX_W-1:0]    sel;
    logic                found;
    logic                g_valid;
    logic [DATA_W-1:0]   data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = REQ_DATA[i*DATA_W +: DATA_W];
    end

    rr_pick_comb #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid    (REQ_VALID),
        .last_ptr (last_ptr),
        .sel      (sel),
        .found    (found)
    );

    // While in BURST the owner index is last_ptr, captured at grant time.
    assign g_valid = REQ_VALID[last_ptr];
    assign BUSY    = (state == BURST);

    always_comb begin
        state_n    = state;
        last_ptr_n = last_ptr;
        beat_n     = beat_cnt;
        grant_n    = GRANT;
        stall_n    = STALL_CNT;
        REQ_READY  = '0;
        FIFO_WR_EN = 1'b0;
        FIFO_DIN   = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n    = BURST;
                    last_ptr_n = sel;
                    beat_n     = '0;
                    grant_n    = NUM_REQ'(1'b1) << sel;
                end
            end
            BURST: begin
                FIFO_DIN            = data_arr[last_ptr];
                REQ_READY[last_ptr] = !FIFO_FULL && !RST;
                FIFO_WR_EN          = g_valid && !FIFO_FULL && !RST;
                if (!g_valid) begin
                    state_n = IDLE;
                    grant_n = '0;
                end else if (FIFO_FULL) begin
                    if (STALL_CNT != '1) begin
                        stall_n = STALL_CNT + CNT_W'(1);
                    end
                end else if (beat_cnt == BEAT_W'(BURST_LEN - 1)) begin
                    state_n = IDLE;
                    grant_n = '0;
                end else begin
                    beat_n = beat_cnt + BEAT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            last_ptr  <= IDX_W'(NUM_REQ - 1);
            beat_cnt  <= '0;
            GRANT     <= '0;
            STALL_CNT <= '0;
        end else begin
            state     <= state_n;
            last_ptr  <= last_ptr_n;
            beat_cnt  <= beat_n;
            GRANT     <= grant_n;
            STALL_CNT <= stall_n;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random
// traffic against a cycle-level behavioural model with producer queues.
module tb_fifo_wr_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned BL = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic            fifo_full;

    logic [NR-1:0]   req_ready,  req_ready4;
    logic [7:0]      fifo_din,   fifo_din4;
    logic            fifo_wr_en, fifo_wr_en4;
    logic [NR-1:0]   grant,      grant4;
    logic            busy,       busy4;
    logic [15:0]     stall_cnt;
    logic [3:0]      stall_cnt4;

    fifo_wr_arbiter #(.NUM_REQ(NR), .BURST_LEN(BL), .CNT_W(16)) dut (
        .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_DATA(req_data),
        .REQ_READY(req_ready), .FIFO_FULL(fifo_full), .FIFO_DIN(fifo_din),
        .FIFO_WR_EN(fifo_wr_en), .GRANT(grant), .BUSY(busy), .STALL_CNT(stall_cnt)
    );

    fifo_wr_arbiter #(.NUM_REQ(NR), .BURST_LEN(BL), .CNT_W(4)) dut4 (
        .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_DATA(req_data),
        .REQ_READY(req_ready4), .FIFO_FULL(fifo_full), .FIFO_DIN(fifo_din4),
        .FIFO_WR_EN(fifo_wr_en4), .GRANT(grant4), .BUSY(busy4), .STALL_CNT(stall_cnt4)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] pq [NR][$];
    bit         en [NR];

    int m_busy, m_g, m_last, m_beat, m_stall;

    int         log_p [$];
    int         log_c [$];
    logic [7:0] log_d [$];

    task automatic drive();
        for (int i = 0; i < int'(NR); i++) begin
            req_valid[i] = en[i] && (pq[i].size() > 0);
            req_data[i*8 +: 8] = req_valid[i] ? pq[i][0] : 8'h00;
        end
    endtask

    // One clock: drive, compare against the model, advance the model.
    task automatic cycle();
        logic [NR-1:0] e_grant, e_ready;
        logic          e_wr, e_busy;
        logic [7:0]    e_din;
        int            sel, lim4;
        drive();
        #2;
        e_busy  = (m_busy != 0);
        e_grant = '0;
        e_ready = '0;
        if (e_busy) begin
            e_grant[m_g] = 1'b1;
            if (!fifo_full && !rst) e_ready[m_g] = 1'b1;
        end
        e_wr  = e_busy && req_valid[m_g] && !fifo_full && !rst;
        e_din = e_busy ? req_data[m_g*8 +: 8] : 8'h00;
        lim4  = (m_stall > 15) ? 15 : m_stall;

        n_cmp++;
        if (fifo_wr_en !== e_wr) begin
            n_err++; $display("FAIL wr_en cyc=%0d got=%b exp=%b", cyc, fifo_wr_en, e_wr);
        end
        n_cmp++;
        if (fifo_din !== e_din) begin
            n_err++; $display("FAIL din cyc=%0d got=%h exp=%h", cyc, fifo_din, e_din);
        end
        n_cmp++;
        if (grant !== e_grant) begin
            n_err++; $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, grant, e_grant);
        end
        n_cmp++;
        if (busy !== e_busy) begin
            n_err++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy);
        end
        n_cmp++;
        if (req_ready !== e_ready) begin
            n_err++; $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready);
        end
        n_cmp++;
        if (stall_cnt !== 16'(m_stall)) begin
            n_err++; $display("FAIL stall cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, m_stall);
        end
        n_cmp++;
        if (stall_cnt4 !== 4'(lim4)) begin
            n_err++; $display("FAIL stall4 cyc=%0d got=%0d exp=%0d", cyc, stall_cnt4, lim4);
        end
        n_cmp++;
        if ({req_ready4, fifo_din4, fifo_wr_en4, grant4, busy4} !==
            {e_ready, e_din, e_wr, e_grant, e_busy}) begin
            n_err++; $display("FAIL dut4_outs cyc=%0d got=%h exp=%h", cyc,
                {req_ready4, fifo_din4, fifo_wr_en4, grant4, busy4},
                {e_ready, e_din, e_wr, e_grant, e_busy});
        end
        n_cmp++;
        if (!$onehot0(grant)) begin
            n_err++; $display("FAIL grant_onehot cyc=%0d got=%b exp=onehot0", cyc, grant);
        end

        if (e_wr) begin
            log_p.push_back(m_g);
            log_c.push_back(cyc);
            log_d.push_back(e_din);
            void'(pq[m_g].pop_front());
        end

        if (rst) begin
            m_busy = 0; m_last = NR - 1; m_beat = 0; m_stall = 0;
        end else if (!e_busy) begin
            sel = -1;
            for (int k = 1; k <= int'(NR); k++) begin
                if (sel < 0 && req_valid[(m_last + k) % NR]) sel = (m_last + k) % NR;
            end
            if (sel >= 0) begin
                m_busy = 1; m_g = sel; m_last = sel; m_beat = 0;
            end
        end else if (!req_valid[m_g]) begin
            m_busy = 0;
        end else if (fifo_full) begin
            if (m_stall < 65535) m_stall++;
        end else if (m_beat == int'(BL) - 1) begin
            m_busy = 0;
        end else begin
            m_beat++;
        end

        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_env();
        for (int i = 0; i < int'(NR); i++) begin
            en[i] = 1'b0;
            pq[i].delete();
        end
        fifo_full = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cyc = 0;
        log_p.delete(); log_c.delete(); log_d.delete();
    endtask

    task automatic fill(input int p, input logic [7:0] base, input int n);
        for (int j = 0; j < n; j++) pq[p].push_back(8'(base + 8'(j)));
    endtask

    task automatic test_reset();
        clear_env();
        for (int i = 0; i < int'(NR); i++) begin
            en[i] = 1'b1;
            fill(i, 8'(i * 16), 2);
        end
        rst = 1'b1;
        cycle();
        cycle();
        n_cmp++;
        if ({grant, busy, stall_cnt, req_ready, fifo_wr_en} !== '0) begin
            n_err++; $display("FAIL reset_outs got=%h exp=0",
                {grant, busy, stall_cnt, req_ready, fifo_wr_en});
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        clear_env();
        do_reset();
        fill(0, 8'hA0, 6);
        en[0] = 1'b1;
        cycle();
        n_cmp++;
        if (grant !== 4'b0001) begin
            n_err++; $display("FAIL single_grant_latency got=%b exp=0001", grant);
        end
        for (int c = 1; c < 10; c++) cycle();
        n_cmp++;
        if (log_p.size() != 6) begin
            n_err++; $display("FAIL single_count got=%0d exp=6", log_p.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_cmp++;
                if (log_d[k] !== 8'(8'hA0 + k) || log_c[k] != 1 + k % 4 + 5 * (k / 4) || log_p[k] != 0) begin
                    n_err++; $display("FAIL single_word%0d got=%h@%0d exp=%h@%0d", k,
                        log_d[k], log_c[k], 8'(8'hA0 + k), 1 + k % 4 + 5 * (k / 4));
                end
            end
        end
    endtask

    task automatic test_round_robin();
        clear_env();
        do_reset();
        for (int i = 0; i < int'(NR); i++) begin
            en[i] = 1'b1;
            fill(i, 8'(i * 16), 8);
        end
        for (int c = 0; c < 30; c++) cycle();
        n_cmp++;
        if (log_p.size() != 24) begin
            n_err++; $display("FAIL rr_count got=%0d exp=24", log_p.size());
        end else begin
            for (int k = 0; k < 24; k++) begin
                n_cmp++;
                if (log_p[k] != (k / 4) % 4 || log_c[k] != 1 + k % 4 + 5 * (k / 4) ||
                    log_d[k] !== 8'(((k / 4) % 4) * 16 + (k / 16) * 4 + k % 4)) begin
                    n_err++; $display("FAIL rr_word%0d got=p%0d@%0d exp=p%0d@%0d", k,
                        log_p[k], log_c[k], (k / 4) % 4, 1 + k % 4 + 5 * (k / 4));
                end
            end
        end
    endtask

    task automatic test_stall();
        int exp_c [4] = '{1, 2, 8, 9};
        clear_env();
        do_reset();
        fill(2, 8'h20, 4);
        en[2] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            fifo_full = (c >= 3 && c <= 7);
            cycle();
        end
        n_cmp++;
        if (stall_cnt !== 16'd5) begin
            n_err++; $display("FAIL stall_total got=%0d exp=5", stall_cnt);
        end
        n_cmp++;
        if (log_p.size() != 4) begin
            n_err++; $display("FAIL stall_count got=%0d exp=4", log_p.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (log_p[k] != 2 || log_c[k] != exp_c[k] || log_d[k] !== 8'(8'h20 + k)) begin
                    n_err++; $display("FAIL stall_word%0d got=p%0d@%0d exp=p2@%0d", k,
                        log_p[k], log_c[k], exp_c[k]);
                end
            end
        end
    endtask

    task automatic test_early_exit();
        int         exp_p [5] = '{1, 3, 3, 3, 3};
        int         exp_c [5] = '{1, 4, 5, 6, 7};
        logic [7:0] exp_d [5] = '{8'h10, 8'h30, 8'h31, 8'h32, 8'h33};
        clear_env();
        do_reset();
        fill(1, 8'h10, 1);
        fill(3, 8'h30, 4);
        en[1] = 1'b1;
        en[3] = 1'b1;
        for (int c = 0; c < 10; c++) cycle();
        n_cmp++;
        if (log_p.size() != 5) begin
            n_err++; $display("FAIL early_count got=%0d exp=5", log_p.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (log_p[k] != exp_p[k] || log_c[k] != exp_c[k] || log_d[k] !== exp_d[k]) begin
                    n_err++; $display("FAIL early_word%0d got=p%0d@%0d exp=p%0d@%0d", k,
                        log_p[k], log_c[k], exp_p[k], exp_c[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int exp_c [6] = '{1, 2, 5, 6, 7, 8};
        clear_env();
        do_reset();
        for (int i = 0; i < int'(NR); i++) begin
            en[i] = 1'b1;
            fill(i, 8'(i * 16), 6);
        end
        for (int c = 0; c < 10; c++) begin
            rst = (c == 3);
            cycle();
            if (c == 3) begin
                n_cmp++;
                if (grant !== '0 || stall_cnt !== '0 || busy !== 1'b0) begin
                    n_err++; $display("FAIL midreset_state got=%b/%0d/%b exp=0000/0/0",
                        grant, stall_cnt, busy);
                end
            end
        end
        n_cmp++;
        if (log_p.size() != 6) begin
            n_err++; $display("FAIL midreset_count got=%0d exp=6", log_p.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_cmp++;
                if (log_p[k] != 0 || log_c[k] != exp_c[k] || log_d[k] !== 8'(k)) begin
                    n_err++; $display("FAIL midreset_word%0d got=p%0d@%0d exp=p0@%0d", k,
                        log_p[k], log_c[k], exp_c[k]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        clear_env();
        do_reset();
        fill(0, 8'h50, 30);
        en[0] = 1'b1;
        for (int c = 0; c < 25; c++) begin
            fifo_full = (c >= 1 && c <= 20);
            cycle();
            if (c == 17) begin
                n_cmp++;
                if (stall_cnt4 !== 4'd15) begin
                    n_err++; $display("FAIL sat_mid got=%0d exp=15", stall_cnt4);
                end
            end
        end
        n_cmp++;
        if (stall_cnt4 !== 4'd15 || stall_cnt !== 16'd20) begin
            n_err++; $display("FAIL sat_end got=%0d/%0d exp=15/20", stall_cnt4, stall_cnt);
        end
    endtask

    task automatic test_random();
        clear_env();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < int'(NR); i++) begin
                if ($urandom % 8 == 0) en[i] = !en[i];
                if (pq[i].size() < 3) pq[i].push_back(8'($urandom));
            end
            fifo_full = ($urandom % 4 == 0);
            rst       = ($urandom % 97 == 0);
            cycle();
        end
        rst = 1'b0;
        log_p.delete(); log_c.delete(); log_d.delete();
    endtask

    initial begin
        m_busy = 0; m_g = 0; m_last = NR - 1; m_beat = 0; m_stall = 0;
        clear_env();
        req_valid = '0;
        req_data  = '0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);

        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_early_exit();
        test_reset_mid_burst();
        test_saturation();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
